// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg
//   Shared types and constants for the register access arbiter.
//   - state_t   : arbiter FSM states
//   - req_idx_t : requester index (0 = UART command path, 1 = local host)
//   - NUM_REQ   : number of requesters
//   - onehot_to_idx : converts a one-hot two-requester grant to an index

package reg_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_idx_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_ISSUE = 2'd2,
        READ_WAIT  = 2'd3
    } state_t;

    // With only two requesters the index is simply the upper grant bit.
    function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin grant selection.  Purely combinational.
//   Ports:
//     valid [1:0] : request valid per requester
//     last        : index of the requester granted most recently
//     grant [1:0] : one-hot grant, all zeros when nothing is valid
//   When both requesters are valid the one that was not granted last wins;
//   a lone valid requester is always granted.

module rr_arbiter2
    import reg_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  req_idx_t           last,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant    = '0;
        grant[0] = valid[0] & (~valid[1] | (last == 1'b1));
        grant[1] = valid[1] & (~valid[0] | (last == 1'b0));
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//   Arbitrates two requesters (0 = UART command path, 1 = local host) onto a
//   single register-file write port and read port, and routes read
//   responses back to the requester that issued the read.
//
//   Parameters:
//     WORD_WIDTH     : address width and serial word width
//     VALUE_WORDS    : register value width in words (D = VALUE_WORDS*WORD_WIDTH)
//     TIMEOUT_CYCLES : read-wait limit in clk cycles (1..65535)
//
//   Ports:
//     clk, i_reset_n                   : clock, asynchronous active-low reset
//     i_req_valid/we/addr/wdata [1:0]  : per-requester request
//     o_req_ready [1:0]                : request accepted this cycle
//     o_w_en/o_w_addr/o_w_data         : register-file write port
//     o_r_en/o_r_addr, i_r_data/valid  : register-file read port
//     o_rsp_valid [1:0], o_rsp_data,
//     o_rsp_err                        : read response, routed per requester
//     o_dbg_state                      : current FSM state (observation only)
//
//   Handshake: a request on requester k transfers on a rising edge where
//   i_req_valid[k] and o_req_ready[k] are both 1.  o_req_ready is only ever
//   asserted in IDLE, for at most one requester, and does not depend on
//   i_req_we/addr/wdata.  o_rsp_valid is a single-cycle pulse with no
//   back-pressure.
//
//   Build option: define REG_ARB_TIMEOUT_EN to enable the read timeout.
//   Without it READ_WAIT waits indefinitely and o_rsp_err is tied 0.

module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WORD_WIDTH     = 8,
    parameter int VALUE_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                      clk,
    input  logic                                      i_reset_n,
    input  logic [1:0]                                i_req_valid,
    input  logic [1:0]                                i_req_we,
    input  logic [1:0][WORD_WIDTH-1:0]                i_req_addr,
    input  logic [1:0][VALUE_WORDS*WORD_WIDTH-1:0]    i_req_wdata,
    output logic [1:0]                                o_req_ready,
    output logic                                      o_w_en,
    output logic [WORD_WIDTH-1:0]                     o_w_addr,
    output logic [VALUE_WORDS*WORD_WIDTH-1:0]         o_w_data,
    output logic                                      o_r_en,
    output logic [WORD_WIDTH-1:0]                     o_r_addr,
    input  logic [VALUE_WORDS*WORD_WIDTH-1:0]         i_r_data,
    input  logic                                      i_r_valid,
    output logic [1:0]                                o_rsp_valid,
    output logic [VALUE_WORDS*WORD_WIDTH-1:0]         o_rsp_data,
    output logic                                      o_rsp_err,
    output state_t                                    o_dbg_state
);

    localparam int D = VALUE_WORDS * WORD_WIDTH;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("reg_access_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t               state_q, state_d;
    req_idx_t             last_q;
    req_idx_t             idx_q;
    req_idx_t             acc_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic                 rsp_fire;
    logic [WORD_WIDTH-1:0] addr_q;
    logic [D-1:0]         data_q;
    logic [1:0]           rsp_valid_q;
    logic [D-1:0]         rsp_data_q;

    rr_arbiter2 u_rr (
        .valid (i_req_valid),
        .last  (last_q),
        .grant (grant)
    );

    assign acc_idx = onehot_to_idx(grant);
    assign accept  = (state_q == IDLE) && (grant != '0);

`ifdef REG_ARB_TIMEOUT_EN
    // The timeout fires after TIMEOUT_CYCLES full cycles spent in READ_WAIT,
    // i.e. on the cycle where the counter shows TIMEOUT_CYCLES-1.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_q;
    logic        rsp_timeout;
    logic        rsp_err_q;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rsp_fire = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
        rsp_timeout = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = i_req_we[acc_idx] ? WRITE : READ_ISSUE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ_ISSUE: begin
                state_d = READ_WAIT;
            end
            READ_WAIT: begin
                // A response arriving on the limit cycle takes precedence.
                if (i_r_valid) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    rsp_fire    = 1'b1;
                    rsp_timeout = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_q <= 1'b1;
            idx_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            last_q <= acc_idx;
            idx_q  <= acc_idx;
            addr_q <= i_req_addr[acc_idx];
            data_q <= i_req_wdata[acc_idx];
        end
    end

    // ------------------------------------------------------------------
    // Read response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (rsp_fire) begin
                rsp_valid_q[idx_q] <= 1'b1;
`ifdef REG_ARB_TIMEOUT_EN
                rsp_data_q <= rsp_timeout ? '0 : i_r_data;
`else
                rsp_data_q <= i_r_data;
`endif
            end
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            rsp_err_q <= rsp_fire & rsp_timeout;
            if ((state_q == READ_WAIT) && (state_d == READ_WAIT)) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    assign o_rsp_err = rsp_err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign o_w_en      = (state_q == WRITE);
    assign o_w_addr    = addr_q;
    assign o_w_data    = data_q;
    assign o_r_en      = (state_q == READ_ISSUE);
    assign o_r_addr    = addr_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter
//   Directed bench for reg_access_arbiter: reset state, single write,
//   two-requester contention, read routing, stray read-valid, reset during
//   READ_WAIT and the read-wait behaviour (timeout with REG_ARB_TIMEOUT_EN,
//   indefinite wait without).  Inputs change 1 ns after the rising edge,
//   outputs are sampled on the falling edge.

module tb_reg_access_arbiter;
    import reg_arb_pkg::*;

    localparam int WW = 8;
    localparam int VW = 4;
    localparam int D  = WW * VW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic i_reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          i_req_valid = '0;
    logic [1:0]          i_req_we    = '0;
    logic [1:0][WW-1:0]  i_req_addr  = '0;
    logic [1:0][D-1:0]   i_req_wdata = '0;
    logic [1:0]          o_req_ready;
    logic                o_w_en;
    logic [WW-1:0]       o_w_addr;
    logic [D-1:0]        o_w_data;
    logic                o_r_en;
    logic [WW-1:0]       o_r_addr;
    logic [D-1:0]        i_r_data = '0;
    logic                i_r_valid = 1'b0;
    logic [1:0]          o_rsp_valid;
    logic [D-1:0]        o_rsp_data;
    logic                o_rsp_err;
    state_t              o_dbg_state;

    reg_access_arbiter #(
        .WORD_WIDTH     (WW),
        .VALUE_WORDS    (VW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_req_valid (i_req_valid),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_req_ready (o_req_ready),
        .o_w_en      (o_w_en),
        .o_w_addr    (o_w_addr),
        .o_w_data    (o_w_data),
        .o_r_en      (o_r_en),
        .o_r_addr    (o_r_addr),
        .i_r_data    (i_r_data),
        .i_r_valid   (i_r_valid),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [0:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic to_drive;  // just after the rising edge
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample;
        @(negedge clk);
    endtask

    task automatic apply_reset(input int cycles);
        i_reset_n = 1'b0;
        repeat (cycles) to_drive();
        i_reset_n = 1'b1;
    endtask

    task automatic set_req(input int k, input logic we, input logic [WW-1:0] a, input logic [D-1:0] d);
        i_req_valid[k] = 1'b1;
        i_req_we[k]    = we;
        i_req_addr[k]  = a;
        i_req_wdata[k] = d;
    endtask

    int cnt_a, cnt_b, n_grant;
    logic [0:0] exp_g;

    initial begin
        // ---------------- reset state ----------------
        to_sample();
        check_eq("rst_ready",     o_req_ready, 2'b00);
        check_eq("rst_w_en",      o_w_en, 1'b0);
        check_eq("rst_r_en",      o_r_en, 1'b0);
        check_eq("rst_rsp_valid", o_rsp_valid, 2'b00);
        check_eq("rst_rsp_err",   o_rsp_err, 1'b0);
        check_eq("rst_w_addr",    o_w_addr, 8'h00);
        check_eq("rst_w_data",    o_w_data, 32'h0);
        check_eq("rst_r_addr",    o_r_addr, 8'h00);
        check_eq("rst_rsp_data",  o_rsp_data, 32'h0);
        check_eq("rst_state",     o_dbg_state, IDLE);
        to_drive();
        i_reset_n = 1'b1;

        // ---------------- single write ----------------
        set_req(0, 1'b1, 8'h12, 32'hDEADBEEF);
        to_sample();
        check_eq("wr_ready_N", o_req_ready, 2'b01);
        check_eq("wr_w_en_N",  o_w_en, 1'b0);
        to_drive();
        i_req_valid = '0;
        to_sample();
        check_eq("wr_w_en_N1",   o_w_en, 1'b1);
        check_eq("wr_w_addr_N1", o_w_addr, 8'h12);
        check_eq("wr_w_data_N1", o_w_data, 32'hDEADBEEF);
        check_eq("wr_ready_N1",  o_req_ready, 2'b00);
        to_drive();
        to_sample();
        check_eq("wr_w_en_N2",    o_w_en, 1'b0);
        check_eq("wr_addr_hold",  o_w_addr, 8'h12);
        check_eq("wr_rsp_valid",  o_rsp_valid, 2'b00);

        // ---------------- contention ----------------
        to_drive();
        apply_reset(2);
        for (int i = 0; i < 8; i++) exp_q.push_back(1'(i % 2));
        set_req(0, 1'b1, 8'h20, 32'h0000_00A0);
        set_req(1, 1'b1, 8'h30, 32'h0000_00B0);
        cnt_a = 0; cnt_b = 0; n_grant = 0;
        for (int c = 0; c < 16; c++) begin
            to_sample();
            if (o_w_en && o_w_addr == 8'h20) cnt_a++;
            if (o_w_en && o_w_addr == 8'h30) cnt_b++;
            if (o_req_ready != 2'b00) begin
                n_grant++;
                exp_g = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
                check_eq("rr_grant_onehot", o_req_ready == 2'b01 || o_req_ready == 2'b10, 1'b1);
                check_eq("rr_grant_order", o_req_ready[1], exp_g);
            end
            to_drive();
        end
        i_req_valid = '0;
        check_eq("rr_grant_count", n_grant, 8);
        check_eq("rr_left_in_q",   exp_q.size(), 0);
        check_eq("rr_writes_req0", cnt_a, 4);
        check_eq("rr_writes_req1", cnt_b, 4);

        // ---------------- read routing (requester 1) ----------------
        set_req(1, 1'b0, 8'h05, 32'h0);
        to_sample();
        check_eq("rd_ready_N", o_req_ready, 2'b10);
        to_drive();
        i_req_valid = '0;
        to_sample();
        check_eq("rd_r_en_N1",   o_r_en, 1'b1);
        check_eq("rd_r_addr_N1", o_r_addr, 8'h05);
        to_drive();
        to_sample();
        check_eq("rd_r_en_N2", o_r_en, 1'b0);
        to_drive();
        to_sample();
        check_eq("rd_wait_N3", o_rsp_valid, 2'b00);
        to_drive();
        i_r_valid = 1'b1;
        i_r_data  = 32'h0000CAFE;
        to_sample();
        check_eq("rd_wait_N4", o_rsp_valid, 2'b00);
        to_drive();
        i_r_valid = 1'b0;
        i_r_data  = 32'h0;
        to_sample();
        check_eq("rd_rsp_valid", o_rsp_valid, 2'b10);
        check_eq("rd_rsp_data",  o_rsp_data, 32'h0000CAFE);
        check_eq("rd_rsp_err",   o_rsp_err, 1'b0);
        to_drive();
        to_sample();
        check_eq("rd_rsp_pulse", o_rsp_valid, 2'b00);
        check_eq("rd_data_hold", o_rsp_data, 32'h0000CAFE);

        // ---------------- stray read-valid in IDLE ----------------
        to_drive();
        i_r_valid = 1'b1;
        i_r_data  = 32'h1111_2222;
        to_drive();
        i_r_valid = 1'b0;
        to_sample();
        check_eq("stray_rsp_valid", o_rsp_valid, 2'b00);
        check_eq("stray_rsp_data",  o_rsp_data, 32'h0000CAFE);

        // ---------------- reset during READ_WAIT ----------------
        to_drive();
        set_req(0, 1'b0, 8'h07, 32'h0);
        to_drive();
        i_req_valid = '0;
        to_drive();
        to_sample();
        check_eq("rw_in_wait", o_dbg_state, READ_WAIT);
        to_drive();
        apply_reset(2);
        i_r_valid = 1'b1;
        i_r_data  = 32'h5555_AAAA;
        to_drive();
        i_r_valid = 1'b0;
        to_sample();
        check_eq("rw_no_rsp",     o_rsp_valid, 2'b00);
        check_eq("rw_state_idle", o_dbg_state, IDLE);
        to_drive();
        set_req(0, 1'b1, 8'h40, 32'h4);
        set_req(1, 1'b1, 8'h41, 32'h5);
        to_sample();
        check_eq("rw_grant_req0", o_req_ready, 2'b01);
        to_drive();
        i_req_valid = '0;
        to_drive();

        // ---------------- read wait behaviour ----------------
        set_req(0, 1'b0, 8'h09, 32'h0);
        to_drive();
        i_req_valid = '0;
        to_drive();
`ifdef REG_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            to_sample();
            check_eq("to_wait_no_rsp", o_rsp_valid, 2'b00);
            to_drive();
        end
        to_sample();
        check_eq("to_rsp_valid", o_rsp_valid, 2'b01);
        check_eq("to_rsp_err",   o_rsp_err, 1'b1);
        check_eq("to_rsp_data",  o_rsp_data, 32'h0);
        to_drive();
        i_r_valid = 1'b1;
        i_r_data  = 32'h7777_7777;
        to_sample();
        check_eq("to_err_pulse", o_rsp_err, 1'b0);
        to_drive();
        i_r_valid = 1'b0;
        to_sample();
        check_eq("to_stray_rsp", o_rsp_valid, 2'b00);
        check_eq("to_stray_data", o_rsp_data, 32'h0);
`else
        for (int c = 0; c < 10; c++) begin
            to_sample();
            check_eq("wait_no_rsp", o_rsp_valid, 2'b00);
            to_drive();
        end
        to_sample();
        check_eq("wait_state", o_dbg_state, READ_WAIT);
        to_drive();
        i_r_valid = 1'b1;
        i_r_data  = 32'h0BAD_F00D;
        to_drive();
        i_r_valid = 1'b0;
        to_sample();
        check_eq("wait_rsp_valid", o_rsp_valid, 2'b01);
        check_eq("wait_rsp_data",  o_rsp_data, 32'h0BAD_F00D);
        check_eq("wait_rsp_err",   o_rsp_err, 1'b0);
`endif

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
